// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the two-master AXI4-Lite arbiter: FSM encoding,
// port index constants and AXI response codes.
package axi_lite_arbiter_pkg;

  localparam int unsigned PORT_N = 2;
  localparam int unsigned PROT_W = 3;
  localparam int unsigned RESP_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_e;

  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_arb_pick.sv
// Winner selection for the arbiter (purely combinational).
//   i_req    : per-port request vector (bit index = port)
//   i_last   : port granted last (used only when ARB_ROUND_ROBIN_EN is defined)
//   o_winner : selected port; meaningful only when i_req != 0
// Macro ARB_ROUND_ROBIN_EN: on a tie the port not granted last wins;
// otherwise the LSU port always wins a tie.
module axi_arb_pick
  import axi_lite_arbiter_pkg::*;
(
  input  logic [PORT_N-1:0] i_req,
  input  logic              i_last,
  output logic              o_winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    o_winner = i_req[PORT_LSU];
    if (&i_req) o_winner = ~i_last;
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    o_winner = i_req[PORT_LSU];
  end
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter with a single outstanding
// transaction. Port 0 is the instruction fetch master, port 1 the load/store
// master. Writes are served before reads when one port requests both.
//   clk, rst          : clock, synchronous active-high reset
//   i_m{0,1}_* / o_m{0,1}_* : slave-side AW/W/B/AR/R channels of each master
//   o_s_* / i_s_*     : master-side channels to the shared slave
//   o_busy            : a transaction is owned by either port
// Macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed LSU priority.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // master port 0
  input  logic [ADDR_W-1:0]   i_m0_awaddr,
  input  logic [PROT_W-1:0]   i_m0_awprot,
  input  logic                i_m0_awvalid,
  output logic                o_m0_awready,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic [DATA_W/8-1:0] i_m0_wstrb,
  input  logic                i_m0_wvalid,
  output logic                o_m0_wready,
  output logic [RESP_W-1:0]   o_m0_bresp,
  output logic                o_m0_bvalid,
  input  logic                i_m0_bready,
  input  logic [ADDR_W-1:0]   i_m0_araddr,
  input  logic [PROT_W-1:0]   i_m0_arprot,
  input  logic                i_m0_arvalid,
  output logic                o_m0_arready,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic [RESP_W-1:0]   o_m0_rresp,
  output logic                o_m0_rvalid,
  input  logic                i_m0_rready,
  // master port 1
  input  logic [ADDR_W-1:0]   i_m1_awaddr,
  input  logic [PROT_W-1:0]   i_m1_awprot,
  input  logic                i_m1_awvalid,
  output logic                o_m1_awready,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wstrb,
  input  logic                i_m1_wvalid,
  output logic                o_m1_wready,
  output logic [RESP_W-1:0]   o_m1_bresp,
  output logic                o_m1_bvalid,
  input  logic                i_m1_bready,
  input  logic [ADDR_W-1:0]   i_m1_araddr,
  input  logic [PROT_W-1:0]   i_m1_arprot,
  input  logic                i_m1_arvalid,
  output logic                o_m1_arready,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic [RESP_W-1:0]   o_m1_rresp,
  output logic                o_m1_rvalid,
  input  logic                i_m1_rready,
  // shared slave
  output logic [ADDR_W-1:0]   o_s_awaddr,
  output logic [PROT_W-1:0]   o_s_awprot,
  output logic                o_s_awvalid,
  input  logic                i_s_awready,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  output logic                o_s_wvalid,
  input  logic                i_s_wready,
  input  logic [RESP_W-1:0]   i_s_bresp,
  input  logic                i_s_bvalid,
  output logic                o_s_bready,
  output logic [ADDR_W-1:0]   o_s_araddr,
  output logic [PROT_W-1:0]   o_s_arprot,
  output logic                o_s_arvalid,
  input  logic                i_s_arready,
  input  logic [DATA_W-1:0]   i_s_rdata,
  input  logic [RESP_W-1:0]   i_s_rresp,
  input  logic                i_s_rvalid,
  output logic                o_s_rready,
  output logic                o_busy
);

  // Master-side signals gathered into per-port arrays, indexed by owner.
  logic [ADDR_W-1:0]   w_awaddr [PORT_N];
  logic [PROT_W-1:0]   w_awprot [PORT_N];
  logic [DATA_W-1:0]   w_wdata  [PORT_N];
  logic [DATA_W/8-1:0] w_wstrb  [PORT_N];
  logic [ADDR_W-1:0]   w_araddr [PORT_N];
  logic [PROT_W-1:0]   w_arprot [PORT_N];
  logic [PORT_N-1:0]   w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic [PORT_N-1:0]   w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic [RESP_W-1:0]   w_bresp  [PORT_N];
  logic [DATA_W-1:0]   w_rdata  [PORT_N];
  logic [RESP_W-1:0]   w_rresp  [PORT_N];

  assign w_awaddr[0] = i_m0_awaddr;  assign w_awaddr[1] = i_m1_awaddr;
  assign w_awprot[0] = i_m0_awprot;  assign w_awprot[1] = i_m1_awprot;
  assign w_wdata[0]  = i_m0_wdata;   assign w_wdata[1]  = i_m1_wdata;
  assign w_wstrb[0]  = i_m0_wstrb;   assign w_wstrb[1]  = i_m1_wstrb;
  assign w_araddr[0] = i_m0_araddr;  assign w_araddr[1] = i_m1_araddr;
  assign w_arprot[0] = i_m0_arprot;  assign w_arprot[1] = i_m1_arprot;
  assign w_awvalid   = {i_m1_awvalid, i_m0_awvalid};
  assign w_wvalid    = {i_m1_wvalid,  i_m0_wvalid};
  assign w_bready    = {i_m1_bready,  i_m0_bready};
  assign w_arvalid   = {i_m1_arvalid, i_m0_arvalid};
  assign w_rready    = {i_m1_rready,  i_m0_rready};

  assign o_m0_awready = w_awready[0];  assign o_m1_awready = w_awready[1];
  assign o_m0_wready  = w_wready[0];   assign o_m1_wready  = w_wready[1];
  assign o_m0_bvalid  = w_bvalid[0];   assign o_m1_bvalid  = w_bvalid[1];
  assign o_m0_bresp   = w_bresp[0];    assign o_m1_bresp   = w_bresp[1];
  assign o_m0_arready = w_arready[0];  assign o_m1_arready = w_arready[1];
  assign o_m0_rvalid  = w_rvalid[0];   assign o_m1_rvalid  = w_rvalid[1];
  assign o_m0_rdata   = w_rdata[0];    assign o_m1_rdata   = w_rdata[1];
  assign o_m0_rresp   = w_rresp[0];    assign o_m1_rresp   = w_rresp[1];

  arb_state_e        r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_ar_done, r_aw_done, r_w_done;
  logic              w_ar_done_nxt, w_aw_done_nxt, w_w_done_nxt;
  logic [PORT_N-1:0] w_req;
  logic              w_winner;
  logic              w_last;

  assign w_req  = w_arvalid | w_awvalid;
  assign o_busy = (r_state != IDLE);

  axi_arb_pick u_pick (
    .i_req    (w_req),
    .i_last   (w_last),
    .o_winner (w_winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Port granted most recently; the other port wins the next tie.
  logic r_last;
  always_ff @(posedge clk) begin
    if (rst) r_last <= PORT_IFU;
    else if (r_state == IDLE && |w_req) r_last <= w_winner;
  end
  assign w_last = r_last;
`else
  assign w_last = PORT_IFU;
`endif

  // State, owner and handshake-done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= PORT_IFU;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_ar_done <= w_ar_done_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  // Next state and channel routing; everything is zero unless owned.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_ar_done_nxt = r_ar_done;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    o_s_awaddr  = '0;  o_s_awprot = '0;  o_s_awvalid = 1'b0;
    o_s_wdata   = '0;  o_s_wstrb  = '0;  o_s_wvalid  = 1'b0;
    o_s_bready  = 1'b0;
    o_s_araddr  = '0;  o_s_arprot = '0;  o_s_arvalid = 1'b0;
    o_s_rready  = 1'b0;
    w_awready = '0;  w_wready = '0;  w_bvalid = '0;
    w_arready = '0;  w_rvalid = '0;
    for (int p = 0; p < int'(PORT_N); p++) begin
      w_bresp[p] = '0;
      w_rdata[p] = '0;
      w_rresp[p] = '0;
    end

    unique case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_owner_nxt = w_winner;
          w_state_nxt = w_awvalid[w_winner] ? WR : RD;
        end
      end
      RD: begin
        o_s_araddr          = w_araddr[r_owner];
        o_s_arprot          = w_arprot[r_owner];
        o_s_arvalid         = w_arvalid[r_owner] & ~r_ar_done;
        w_arready[r_owner]  = i_s_arready & ~r_ar_done;
        o_s_rready          = w_rready[r_owner] & r_ar_done;
        w_rvalid[r_owner]   = i_s_rvalid & r_ar_done;
        w_rdata[r_owner]    = i_s_rdata;
        w_rresp[r_owner]    = i_s_rresp;
        if (o_s_arvalid && i_s_arready) w_ar_done_nxt = 1'b1;
        if (o_s_rready && i_s_rvalid) begin
          w_state_nxt   = IDLE;
          w_ar_done_nxt = 1'b0;
        end
      end
      WR: begin
        o_s_awaddr          = w_awaddr[r_owner];
        o_s_awprot          = w_awprot[r_owner];
        o_s_awvalid         = w_awvalid[r_owner] & ~r_aw_done;
        w_awready[r_owner]  = i_s_awready & ~r_aw_done;
        o_s_wdata           = w_wdata[r_owner];
        o_s_wstrb           = w_wstrb[r_owner];
        o_s_wvalid          = w_wvalid[r_owner] & ~r_w_done;
        w_wready[r_owner]   = i_s_wready & ~r_w_done;
        // B is only passed through once both AW and W have completed.
        o_s_bready          = w_bready[r_owner] & r_aw_done & r_w_done;
        w_bvalid[r_owner]   = i_s_bvalid & r_aw_done & r_w_done;
        w_bresp[r_owner]    = i_s_bresp;
        if (o_s_awvalid && i_s_awready) w_aw_done_nxt = 1'b1;
        if (o_s_wvalid && i_s_wready)   w_w_done_nxt  = 1'b1;
        if (o_s_bready && i_s_bvalid) begin
          w_state_nxt   = IDLE;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of every AR/AW channel.
REQ-002 Parameter DATA_W, default 64, data width; strobe width is DATA_W/8.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset: rst, synchronous, active-high.
REQ-005 m0_aw*/m0_w*/m0_b*  slave-side  AXI4-Lite write channels (addr/prot/valid/ready, data/strb/valid/ready, resp/valid/ready); port 0 is the instruction fetch master.
REQ-006 m0_ar*/m0_r*  slave-side  AXI4-Lite read channels (addr/prot/valid/ready, data/resp/valid/ready) for port 0.
REQ-007 m1_aw*/m1_w*/m1_b*/m1_ar*/m1_r*  slave-side  the same channel set for port 1, the load/store master.
REQ-008 s_aw*/s_w*/s_b*/s_ar*/s_r*  master-side  the single shared memory slave, with the same widths.
REQ-009 busy  out  1  high while a transaction is owned by either port.

Function
REQ-010 The arbiter SHALL use FSM states IDLE, RD and WR, with a 1-bit owner register; only one transaction SHALL be outstanding in total.
REQ-011 In IDLE, a port requests when its arvalid or awvalid is high; the arbiter SHALL pick a winner, latch owner, and enter WR if the winner has awvalid, else RD, on the next edge.
REQ-012 If one port asserts both arvalid and awvalid, the arbiter SHALL serve the write first.
REQ-013 Default priority SHALL be fixed: port 1 (LSU) wins when both ports request in the same cycle.
REQ-014 In IDLE, all s_* valids and all m*_ready/m*_valid outputs SHALL be 0; grant adds exactly 1 cycle of latency.
REQ-015 In RD, the owner's AR SHALL be routed to s_ar*. An ar_done flag SHALL set on the s_arvalid&s_arready handshake and force s_arvalid low afterwards. R SHALL be routed back to the owner.
REQ-016 RD SHALL return to IDLE on the cycle after the owner's rvalid&rready handshake.
REQ-017 In WR, AW and W SHALL be routed independently, with aw_done/w_done flags masking each channel after its handshake; either order and simultaneous completion are legal.
REQ-018 WR SHALL return to IDLE on the cycle after the bvalid&bready handshake; B SHALL be accepted only after both aw_done and w_done.
REQ-019 The non-owner SHALL see all its ready/valid inputs-to-master driven 0; its pending valids SHALL be held, never dropped.
REQ-020 rresp and bresp SHALL be forwarded unchanged; the arbiter SHALL NOT generate errors.
REQ-021 busy SHALL equal (state != IDLE).

Reset
REQ-022 On rst, state SHALL go to IDLE, owner to 0, all done flags to 0, and the round-robin pointer to 0; all outputs SHALL be 0 in the following cycle.
REQ-023 rst asserted mid-transaction SHALL abandon the transaction without completing any handshake; masters are reset by the same rst.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN, when defined, SHALL replace fixed priority with round-robin: on simultaneous requests, the port not granted last wins, and the pointer updates on each grant.
REQ-025 Without ARB_ROUND_ROBIN_EN, REQ-013 fixed priority SHALL apply and no pointer register SHALL exist.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE/RD/WR), the port index constants (PORT_IFU=0, PORT_LSU=1) and the AXI resp codes.
REQ-027 A combinational sub-module axi_arb_pick SHALL compute the winner from the request vector and the pointer; all sequencing SHALL stay in axi_lite_arbiter.

Verification
REQ-028 m0 reads 0x8000_0000 alone -> s_arvalid 1 cycle after m0_arvalid, m0_rdata = slave data, then IDLE.
REQ-029 m0 read and m1 write to 0x8000_1000 in the same cycle (fixed priority) -> m1 write completes first, then m0 read; m0_arvalid is held throughout.
REQ-030 With ARB_ROUND_ROBIN_EN, both ports request continuously for 4 transactions -> grants alternate 1,0,1,0.
REQ-031 m1 write with W presented 3 cycles before AW -> a single s_bvalid, both strobes 0xFF delivered, and no duplicate AW/W handshake.
REQ-032 Slave returns rresp=2'b10 -> m1_rresp=2'b10 unchanged.
REQ-033 rst pulsed while in WR after aw_done -> next cycle state is IDLE, busy=0, and all s_* valids are 0.
